// File: rtl/efpga_cpu_bridge.sv
// -----------------------------------------------------------------------------
// efpga_cpu_bridge
// Connects the SoC CPU custom-instruction port to the W_CPU_IO tile column on
// the west edge of the eFPGA. One operand pair is accepted per request and
// driven onto OPA/OPB. A single-cycle start pulse and a per-request toggling
// tag go out on OPC. The fabric result is then collected from RES0/RES1,
// either after a fixed latency or when a done flag with the matching tag
// arrives on RES2 (optionally bounded by a timeout). The result is returned
// to the CPU on a valid/ready response channel.
//
// Ports
//   UserCLK, resetn          fabric clock, async active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op_a/req_op_b        operands, DW bits each
//   req_func                 function code, forwarded on OPC[3:2]
//   req_latency              0 = done mode, otherwise fixed latency L
//   timeout_limit            done-mode timeout in cycles, 0 = disabled
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_timeout    captured {RES1, RES0} and timeout flag
//   busy                     any state other than IDLE
//   OPA/OPB/OPC              to fabric; OPC = {func, tag, start}
//   RES0/RES1/RES2           from fabric; RES2[0] done, RES2[1] tag echo
// -----------------------------------------------------------------------------
module efpga_cpu_bridge #(
    parameter int NTILES = 8,
    parameter int CNT_W  = 8,
    localparam int DW    = 4 * NTILES
) (
    input  logic              UserCLK,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DW-1:0]     req_op_a,
    input  logic [DW-1:0]     req_op_b,
    input  logic [1:0]        req_func,
    input  logic [CNT_W-1:0]  req_latency,
    input  logic [CNT_W-1:0]  timeout_limit,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*DW-1:0]   rsp_data,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [DW-1:0]     OPA,
    output logic [DW-1:0]     OPB,
    output logic [3:0]        OPC,
    input  logic [DW-1:0]     RES0,
    input  logic [DW-1:0]     RES1,
    input  logic [DW-1:0]     RES2
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      opa_q, opa_d;
    logic [DW-1:0]      opb_q, opb_d;
    logic [3:0]         opc_q, opc_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [2*DW-1:0]    rsp_data_q, rsp_data_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic [CNT_W-1:0]   cnt_inc_s;
    logic               done_hit_s;
    logic               tmo_hit_s;
    logic               unused_res2_s;

    // Only the done flag and the tag echo of RES2 carry meaning.
    assign unused_res2_s = ^RES2[DW-1:2];

    // Saturating increment: the counter parks at all-ones instead of wrapping,
    // so an unbounded done-mode wait can never alias onto a timeout value.
    assign cnt_inc_s  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // A done flag only counts when it echoes the tag of the current request.
    assign done_hit_s = RES2[0] && (RES2[1] == opc_q[1]);

    // ">=" so that a limit of 1 (never reachable in WAIT) fires at the first
    // WAIT sample, i.e. behaves like a limit of 2.
    assign tmo_hit_s  = (tmo_q != {CNT_W{1'b0}}) && (cnt_q >= tmo_q);

    // Next-state and datapath update for the request/launch/wait/response FSM.
    always_comb begin
        state_d       = state_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        opc_d         = {opc_q[3:1], 1'b0};
        lat_d         = lat_q;
        tmo_d         = tmo_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    opa_d   = req_op_a;
                    opb_d   = req_op_b;
                    opc_d   = {req_func, ~opc_q[1], 1'b1};
                    lat_d   = req_latency;
                    tmo_d   = timeout_limit;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (lat_q == CNT_W'(1)) begin
                    rsp_data_d    = {RES1, RES0};
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d   = cnt_inc_s;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q != {CNT_W{1'b0}}) begin
                    if (cnt_q >= lat_q) begin
                        rsp_data_d    = {RES1, RES0};
                        rsp_timeout_d = 1'b0;
                        rsp_valid_d   = 1'b1;
                        state_d       = ST_RESP;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else if (done_hit_s) begin
                    // Done takes priority over a coincident timeout.
                    rsp_data_d    = {RES1, RES0};
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if (tmo_hit_s) begin
                    rsp_data_d    = {RES1, RES0};
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            opa_q         <= {DW{1'b0}};
            opb_q         <= {DW{1'b0}};
            opc_q         <= 4'b0000;
            lat_q         <= {CNT_W{1'b0}};
            tmo_q         <= {CNT_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= {(2*DW){1'b0}};
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            opc_q         <= opc_d;
            lat_q         <= lat_d;
            tmo_q         <= tmo_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign OPA         = opa_q;
    assign OPB         = opb_q;
    assign OPC         = opc_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_efpga_cpu_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for efpga_cpu_bridge: directed scenarios followed by randomized
// transactions. Expected capture edge, data and timeout flag come from a
// per-transaction model that scans the RES stimulus tables.
// -----------------------------------------------------------------------------
module tb_efpga_cpu_bridge;

    logic        UserCLK;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op_a;
    logic [31:0] req_op_b;
    logic [1:0]  req_func;
    logic [7:0]  req_latency;
    logic [7:0]  timeout_limit;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] OPA;
    logic [31:0] OPB;
    logic [3:0]  OPC;
    logic [31:0] RES0;
    logic [31:0] RES1;
    logic [31:0] RES2;

    int total;
    int bad;
    logic exp_tag;

    // RES values presented just before edge E_i after accept edge E0
    logic [31:0] res0_seq [0:63];
    logic [31:0] res1_seq [0:63];
    logic [31:0] res2_seq [0:63];

    efpga_cpu_bridge #(.NTILES(8), .CNT_W(8)) dut (
        .UserCLK(UserCLK), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_func(req_func),
        .req_latency(req_latency), .timeout_limit(timeout_limit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy),
        .OPA(OPA), .OPB(OPB), .OPC(OPC),
        .RES0(RES0), .RES1(RES1), .RES2(RES2)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    task automatic step();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seq();
        for (int i = 0; i < 64; i++) begin
            res0_seq[i] = 32'h0;
            res1_seq[i] = 32'h0;
            res2_seq[i] = 32'h0;
        end
    endtask

    // Capture edge index k (relative to accept edge E0) and timeout flag.
    function automatic void predict(input logic [7:0] lat, input logic [7:0] tmo,
                                    input logic tag, output int k, output bit to);
        k  = -1;
        to = 1'b0;
        if (lat != 8'd0) begin
            k = int'(lat);
            return;
        end
        // Done is first looked at on the edge after the launch cycle.
        for (int i = 2; i < 64; i++) begin
            if (res2_seq[i][0] && (res2_seq[i][1] == tag)) begin
                k = i;
                return;
            end
            if ((tmo != 8'd0) && (i >= int'(tmo))) begin
                k  = i;
                to = 1'b1;
                return;
            end
        end
    endfunction

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] f, input logic [7:0] lat,
                           input logic [7:0] tmo, input int hold,
                           input bit pulse, input bit chk_cnt);
        int k;
        bit to;
        logic [63:0] exp_d;
        exp_tag = ~exp_tag;
        predict(lat, tmo, exp_tag, k, to);
        if (k < 1) begin
            chk("model_term", 64'd0, 64'd1);
            return;
        end
        exp_d = {res1_seq[k], res0_seq[k]};

        req_op_a      = a;
        req_op_b      = b;
        req_func      = f;
        req_latency   = lat;
        timeout_limit = tmo;
        req_valid     = 1'b1;
        chk("ready_before_accept", {63'd0, req_ready}, 64'd1);
        step();
        req_valid     = 1'b0;
        req_op_a      = $urandom;
        req_op_b      = $urandom;
        req_latency   = 8'(($urandom_range(0, 3)));
        timeout_limit = 8'(($urandom_range(0, 3)));
        chk("opa_launch", {32'd0, OPA}, {32'd0, a});
        chk("opb_launch", {32'd0, OPB}, {32'd0, b});
        chk("opc_launch", {60'd0, OPC}, {60'd0, f, exp_tag, 1'b1});
        chk("busy_launch", {63'd0, busy}, 64'd1);
        chk("ready_launch", {63'd0, req_ready}, 64'd0);
        if (chk_cnt) chk("cnt_e0", {56'd0, dut.cnt_q}, 64'd1);

        for (int i = 1; i <= k; i++) begin
            RES0 = res0_seq[i];
            RES1 = res1_seq[i];
            RES2 = res2_seq[i];
            step();
            if (i == 1) chk("start_one_cycle", {63'd0, OPC[0]}, 64'd0);
            if (i < k) begin
                chk("no_early_rsp", {63'd0, rsp_valid}, 64'd0);
                if (chk_cnt) chk("cnt_wait", {56'd0, dut.cnt_q}, 64'(i + 1));
            end
        end
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, to});
        RES0 = $urandom;
        RES1 = $urandom;
        RES2 = $urandom;

        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                req_valid = 1'b1;
                req_op_a  = ~a;
            end
            step();
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_data", rsp_data, exp_d);
            chk("hold_timeout", {63'd0, rsp_timeout}, {63'd0, to});
            chk("hold_ready", {63'd0, req_ready}, 64'd0);
            chk("hold_opa", {32'd0, OPA}, {32'd0, a});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_dropped", {63'd0, rsp_valid}, 64'd0);
        chk("ready_after", {63'd0, req_ready}, 64'd1);
        chk("busy_after", {63'd0, busy}, 64'd0);
        chk("opa_held", {32'd0, OPA}, {32'd0, a});
        chk("opc_held", {60'd0, OPC}, {60'd0, f, exp_tag, 1'b0});
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        exp_tag = 1'b0;
        @(negedge UserCLK);
        resetn = 1'b1;
        step();
    endtask

    initial begin
        logic [7:0] lat;
        logic [7:0] tmo;
        logic       tg;
        total = 0;
        bad   = 0;
        exp_tag = 1'b0;
        resetn = 1'b0;
        req_valid = 1'b0; req_op_a = 32'h0; req_op_b = 32'h0; req_func = 2'b00;
        req_latency = 8'd0; timeout_limit = 8'd0; rsp_ready = 1'b0;
        RES0 = 32'h0; RES1 = 32'h0; RES2 = 32'h0;
        clear_seq();
        #12;
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_opa", {32'd0, OPA}, 64'd0);
        chk("rst_opc", {60'd0, OPC}, 64'd0);
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_data", rsp_data, 64'd0);
        @(negedge UserCLK);
        resetn = 1'b1;
        step();

        // Fixed latency L=3 with held results
        for (int i = 0; i < 64; i++) begin
            res0_seq[i] = 32'hCAFEF00D;
            res1_seq[i] = 32'h0BADBEEF;
        end
        run_txn(32'h12345678, 32'h9ABCDEF0, 2'b00, 8'd3, 8'd0, 1, 1'b0, 1'b1);
        chk("fixed_data_const", rsp_data, 64'h0BADBEEF_CAFEF00D);

        // Done mode tag check after reset (tag = 1), then backpressure
        do_reset();
        clear_seq();
        for (int i = 1; i <= 5; i++) begin
            res2_seq[i] = 32'h1;
            res0_seq[i] = 32'h1000 + 32'(i);
        end
        res2_seq[6] = 32'h3;
        res0_seq[6] = 32'hD0D0_0006;
        res1_seq[6] = 32'h5151_0006;
        run_txn(32'hA5A5A5A5, 32'h5A5A5A5A, 2'b10, 8'd0, 8'd0, 6, 1'b1, 1'b0);

        // Back-to-back (tag 0): timeout at 4 with no done
        clear_seq();
        res0_seq[4] = 32'h0000_4444;
        res1_seq[4] = 32'h4444_0000;
        run_txn(32'h11111111, 32'h22222222, 2'b01, 8'd0, 8'd4, 0, 1'b0, 1'b0);

        // Done coinciding with timeout at E4 (tag 1): done wins
        clear_seq();
        res2_seq[4] = 32'h3;
        res0_seq[4] = 32'h0000_7777;
        res1_seq[4] = 32'h7777_0000;
        run_txn(32'h33333333, 32'h44444444, 2'b11, 8'd0, 8'd4, 0, 1'b0, 1'b0);

        // Reset in the middle of WAIT
        exp_tag = ~exp_tag;
        req_op_a = 32'hDEADBEEF; req_op_b = 32'hFEEDFACE; req_func = 2'b01;
        req_latency = 8'd0; timeout_limit = 8'd0; RES2 = 32'h0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("mid_cnt", {56'd0, dut.cnt_q}, 64'd2);
        resetn = 1'b0;
        #1;
        exp_tag = 1'b0;
        chk("mid_opa", {32'd0, OPA}, 64'd0);
        chk("mid_opb", {32'd0, OPB}, 64'd0);
        chk("mid_opc", {60'd0, OPC}, 64'd0);
        chk("mid_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_busy", {63'd0, busy}, 64'd0);
        @(negedge UserCLK);
        resetn = 1'b1;
        RES2 = 32'h3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
            chk("post_rst_novalid", {63'd0, rsp_valid}, 64'd0);
        end

        // Bit mapping
        clear_seq();
        res0_seq[2] = 32'h8000_0000;
        run_txn(32'h00000010, 32'h0, 2'b00, 8'd2, 8'd0, 0, 1'b0, 1'b0);
        chk("map_data31", rsp_data, 64'h0000_0000_8000_0000);

        // L = 1 corner
        clear_seq();
        res0_seq[1] = 32'h0101_0101;
        res1_seq[1] = 32'h1010_1010;
        run_txn(32'hCCCC0001, 32'hCCCC0002, 2'b10, 8'd1, 8'd0, 0, 1'b0, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            clear_seq();
            for (int i = 0; i < 64; i++) begin
                res0_seq[i] = $urandom;
                res1_seq[i] = $urandom;
                res2_seq[i] = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 3) == 0)
                    res2_seq[i][1:0] = {1'($urandom_range(0, 1)), 1'b1};
            end
            if ($urandom_range(0, 1) == 0) begin
                lat = 8'($urandom_range(1, 8));
                tmo = 8'($urandom_range(0, 9));
            end else begin
                lat = 8'd0;
                tmo = 8'($urandom_range(0, 9));
                tg  = ~exp_tag;
                if (tmo == 8'd0) res2_seq[12][1:0] = {tg, 1'b1};
            end
            run_txn($urandom, $urandom, 2'($urandom_range(0, 3)), lat, tmo,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/efpga_cpu_bridge.md
# efpga_cpu_bridge

Sequential bridge between the SoC CPU's custom-instruction port and the W_CPU_IO tile column on the west edge of the eFPGA.
- Accepts one operand pair per request and drives it onto the tiles' OPA/OPB inputs.
- Issues a start pulse and a toggling tag on a dedicated control nibble.
- Collects the fabric result from RES0/RES1/RES2 either after a fixed latency or on a tagged done flag, with an optional timeout.
- Returns the result to the CPU through a valid/ready response channel.

## Interface
- NTILES, 8, number of W_CPU_IO tiles per operand word; DW = 4*NTILES.
- CNT_W, 8, width of the latency/timeout counter and of the limit inputs.

Ports:
- UserCLK  in  1  fabric user clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  high only in IDLE.
- req_op_a / req_op_b  in  DW  operands.
- req_func  in  2  function code forwarded to the fabric.
- req_latency  in  CNT_W  0 = done mode; otherwise fixed-latency mode with L = value.
- timeout_limit  in  CNT_W  done-mode timeout in cycles; 0 disables the timeout.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts the response.
- rsp_data  out  2*DW  {RES1, RES0} captured.
- rsp_timeout  out  1  response was produced by a timeout.
- busy  out  1  high in any state other than IDLE.
- OPA / OPB  out  DW  operands; bit 4k+j drives tile k OPA_Ij / OPB_Ij.
- OPC  out  4  control-tile nibble: [0] start, [1] tag, [3:2] func.
- RES0 / RES1 / RES2  in  DW  bit 4k+j comes from tile k RESn_Oj; only RES2[0] (done) and RES2[1] (tag echo) are used.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid: register op_a→OPA, op_b→OPB, func→OPC[3:2].
  - Toggle OPC[1]; latch req_latency and timeout_limit.
  - Set cnt = 1 and go to LAUNCH.
- LAUNCH (exactly one cycle)
  - OPC[0] = 1.
  - Fixed mode with L == 1: capture results, go to RESP.
  - Otherwise: cnt++ and go to WAIT.
- WAIT, fixed mode: capture when cnt == L, then go to RESP; otherwise cnt++.
- WAIT, done mode:
  - Capture when RES2[0] = 1 and RES2[1] == OPC[1]; rsp_timeout = 0.
  - Else, if timeout_limit ≠ 0 and cnt == timeout_limit: capture with rsp_timeout = 1.
  - Otherwise cnt++.
  - The done flag is never sampled in LAUNCH.
  - A done with a stale tag is ignored.
  - Done and timeout in the same cycle: done wins, rsp_timeout = 0.
- Capture: rsp_data ← {RES1, RES0}.
- RESP
  - rsp_valid = 1; rsp_data and rsp_timeout are held stable.
  - On rsp_ready go to IDLE.
- OPA, OPB and OPC[3:1] hold their values until the next accept, including through IDLE.
- Counter: saturating; it never wraps. With timeout disabled and no done, the bridge stays in WAIT indefinitely.
- Reset values:
  - state = IDLE, req_ready = 1, busy = 0.
  - OPA = OPB = 0, OPC = 0 (so the tag is 1 on the first request).
  - rsp_valid = 0, rsp_data = 0, rsp_timeout = 0, cnt = 0.
- Reset asserted mid-transaction aborts it: all outputs take their reset values asynchronously, and no response is issued.
- req_* inputs outside IDLE are ignored.

## Timing
- Accept edge E0 (req_valid & req_ready): OPA/OPB/OPC[3:1] change after E0; OPC[0] is high for the single cycle between E0 and E1.
- Fixed mode: RES sampled at edge E_L; rsp_valid is high from E_L. L = 1 gives a 2-cycle request-to-response turnaround.
- Done mode: earliest capture is at E2; a timeout captures at E_T with T = timeout_limit (T = 1 behaves like T = 2).
- Response handshake at edge Er (rsp_valid & rsp_ready): rsp_valid drops and req_ready rises after Er. The next request can be accepted at Er+1, so the minimum spacing is L+2 cycles.
- All outputs are registered (none is combinational from inputs), except req_ready and busy, which are decoded from state only.

## Test plan
- Reset then fixed mode: op_a = 0x12345678, op_b = 0x9ABCDEF0, L = 3, RES0 = 0xCAFEF00D, RES1 = 0x0BADBEEF held. Expect OPC = 0b0011 in the LAUNCH cycle; rsp_valid from E3; rsp_data = 0x0BADBEEF_CAFEF00D; rsp_timeout = 0; cnt observed 1→2→3.
- Done mode, tag check: first request (tag = 1); drive RES2[1:0] = 0b01 (stale tag) for 5 cycles, then 0b11 for one cycle. Expect capture only on the 0b11 cycle and rsp_timeout = 0.
- Timeout: done mode, timeout_limit = 4, RES2 = 0. Expect rsp_valid from E4 with rsp_timeout = 1. Separately, done and timeout coinciding at E4 gives rsp_timeout = 0.
- Backpressure and back-to-back:
  - Hold rsp_ready = 0 for 6 cycles: rsp_data stays stable, req_ready = 0, and a req_valid pulse during RESP is ignored.
  - Release rsp_ready: a new request is accepted at Er+1, the tag toggles to 0, and OPC[0] pulses once.
- Reset mid-WAIT: pull resetn low asynchronously while cnt = 2. Expect immediate OPA = OPB = 0, OPC = 0, rsp_valid = 0 and busy = 0; after release, req_ready = 1 and no spurious response.
- Bit mapping: op_a = 0x00000010. Expect only tile 1 OPA_I0 (OPA[4]) high; RES0[31] is mapped to rsp_data[31].
